// File: rtl/prio_encoder_4to2_latched.sv
// Latched 4-to-2 priority encoder with VALID/ACK handshake.
// Four asynchronous active-low request lines are synchronized and
// edge-detected. Each falling edge sets a sticky pending bit. The
// highest-priority pending line (3 high, 0 low) is then presented as {B,A}.
module prio_encoder_4to2_latched #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EI_L,
    input  logic [3:0] REQ_L,
    input  logic       ACK,
    output logic       A,
    output logic       B,
    output logic       VALID,
    output logic [3:0] PENDING,
    output logic       OVERRUN
);

    localparam int unsigned CW = SYNC_STAGES * 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        CLEAR
    } state_t;

    state_t      state;
    logic [CW-1:0] sync_chain;
    logic [3:0]  sync_out;
    logic [3:0]  hist;
    logic [3:0]  fall;
    logic [3:0]  set_mask;
    logic [3:0]  clr_mask;
    logic        overrun_hit;
    logic [1:0]  code;
    logic [1:0]  top_idx;

    // Synchronizer chain: the newest sample sits in the low nibble.
    // The history flop holds the previous synced value for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_chain <= '1;
            hist       <= '1;
        end else begin
            sync_chain <= {sync_chain[CW-5:0], REQ_L};
            hist       <= sync_out;
        end
    end

    // Edge detect, capture masks and the winning index for a new grant
    always_comb begin
        sync_out    = sync_chain[CW-1 -: 4];
        fall        = hist & ~sync_out;
        set_mask    = fall & {4{~EI_L}};
        clr_mask    = (state == CLEAR) ? (4'b0001 << code) : 4'b0000;
        // A set that lands in the same cycle as the clear wins, so it is not an overrun
        overrun_hit = |(set_mask & PENDING & ~clr_mask);
        top_idx     = 2'd0;
        if (PENDING[3]) begin
            top_idx = 2'd3;
        end else if (PENDING[2]) begin
            top_idx = 2'd2;
        end else if (PENDING[1]) begin
            top_idx = 2'd1;
        end
    end

    // Sticky pending bits: set has priority over the CLEAR-cycle clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PENDING <= '0;
            OVERRUN <= 1'b0;
        end else begin
            PENDING <= (PENDING & ~clr_mask) | set_mask;
            OVERRUN <= overrun_hit;
        end
    end

    // Grant handshake FSM with registered outputs.
    // code keeps the granted index through CLEAR while {B,A} reads zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            code  <= '0;
            A     <= 1'b0;
            B     <= 1'b0;
            VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!EI_L && (PENDING != 4'b0000)) begin
                        state <= GRANT;
                        code  <= top_idx;
                        B     <= top_idx[1];
                        A     <= top_idx[0];
                        VALID <= 1'b1;
                    end
                end
                GRANT: begin
                    if (ACK) begin
                        state <= CLEAR;
                        A     <= 1'b0;
                        B     <= 1'b0;
                        VALID <= 1'b0;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    A     <= 1'b0;
                    B     <= 1'b0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_4to2_latched.sv
// Self-checking bench for prio_encoder_4to2_latched.
// Expected grant codes are queued as requests are driven.
// A monitor pops and compares them when VALID rises.
module tb_prio_encoder_4to2_latched;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       EI_L  = 1'b0;
    logic [3:0] REQ_L = 4'b0000;
    logic       ACK   = 1'b0;
    logic       A;
    logic       B;
    logic       VALID;
    logic [3:0] PENDING;
    logic       OVERRUN;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] exp_q[$];
    logic [1:0] exp_code;
    logic       valid_d = 1'b0;

    prio_encoder_4to2_latched #(.SYNC_STAGES(2)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .EI_L   (EI_L),
        .REQ_L  (REQ_L),
        .ACK    (ACK),
        .A      (A),
        .B      (B),
        .VALID  (VALID),
        .PENDING(PENDING),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Scoreboard monitor: pops the expected code on each grant and checks that {B,A} is 0 while VALID is 0
    always @(negedge CLK) begin
        if (VALID === 1'b1 && valid_d !== 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL grant_code: unexpected grant got %b, none expected", {B, A});
            end else begin
                exp_code = exp_q.pop_front();
                if ({B, A} !== exp_code) begin
                    miscompares++;
                    $display("FAIL grant_code: got %b expected %b", {B, A}, exp_code);
                end
            end
        end
        if (VALID === 1'b0) begin
            vectors++;
            if ({B, A} !== 2'b00) begin
                miscompares++;
                $display("FAIL ab_zero_when_idle: got %b expected 00", {B, A});
            end
        end
        valid_d = VALID;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int max_ticks, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_ticks; i++) begin
            tick();
            if (VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle(3);
        vectors++;
        if ({PENDING, VALID, B, A, OVERRUN} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got P=%b V=%b BA=%b O=%b expected all 0", PENDING, VALID, {B, A}, OVERRUN);
        end
        REQ_L = 4'b1111;
        tick();
        RESET = 1'b0;
        idle(5);
        vectors++;
        if ({PENDING, VALID, OVERRUN} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_release: got P=%b V=%b O=%b expected all 0", PENDING, VALID, OVERRUN);
        end
    endtask

    task automatic test_single();
        REQ_L = 4'b1011;
        exp_q.push_back(2'd2);
        idle(2);
        vectors++;
        if (PENDING !== 4'b0000 || VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: got P=%b V=%b expected 0000/0", PENDING, VALID);
        end
        tick();
        vectors++;
        if (PENDING !== 4'b0100 || VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pending_latency: got P=%b V=%b expected 0100/0", PENDING, VALID);
        end
        tick();
        vectors++;
        if (VALID !== 1'b1 || {B, A} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_valid_latency: got V=%b BA=%b expected 1/10", VALID, {B, A});
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        vectors++;
        if (VALID !== 1'b0 || PENDING !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ack: got V=%b P=%b expected 0/0100", VALID, PENDING);
        end
        tick();
        vectors++;
        if (PENDING !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_clear: got P=%b expected 0000", PENDING);
        end
        REQ_L = 4'b1111;
        idle(4);
    endtask

    task automatic test_priority();
        bit ok;
        REQ_L = 4'b0110;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        idle(3);
        vectors++;
        if (PENDING !== 4'b1001) begin
            miscompares++;
            $display("FAIL prio_pending_both: got %b expected 1001", PENDING);
        end
        wait_valid(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL prio_first_grant: VALID got 0 expected 1 within 4 cycles");
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        vectors++;
        if (PENDING !== 4'b0001) begin
            miscompares++;
            $display("FAIL prio_after_first: got %b expected 0001", PENDING);
        end
        wait_valid(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL prio_second_grant: VALID got 0 expected 1 within 4 cycles");
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        vectors++;
        if (PENDING !== 4'b0000) begin
            miscompares++;
            $display("FAIL prio_after_second: got %b expected 0000", PENDING);
        end
        REQ_L = 4'b1111;
        idle(4);
    endtask

    task automatic test_stability();
        bit ok;
        REQ_L = 4'b1101;
        exp_q.push_back(2'd1);
        wait_valid(8, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stab_grant: VALID got 0 expected 1 within 8 cycles");
        end
        REQ_L = 4'b0101;
        exp_q.push_back(2'd3);
        idle(4);
        vectors++;
        if (VALID !== 1'b1 || {B, A} !== 2'b01 || PENDING !== 4'b1010) begin
            miscompares++;
            $display("FAIL stab_hold: got V=%b BA=%b P=%b expected 1/01/1010", VALID, {B, A}, PENDING);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        vectors++;
        if (PENDING !== 4'b1000) begin
            miscompares++;
            $display("FAIL stab_after_ack: got %b expected 1000", PENDING);
        end
        wait_valid(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stab_next_grant: VALID got 0 expected 1 within 4 cycles");
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        vectors++;
        if (PENDING !== 4'b0000) begin
            miscompares++;
            $display("FAIL stab_final: got %b expected 0000", PENDING);
        end
        REQ_L = 4'b1111;
        idle(4);
    endtask

    task automatic test_enable();
        EI_L  = 1'b1;
        REQ_L = 4'b1101;
        idle(5);
        vectors++;
        if (PENDING !== 4'b0000 || VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL en_block_capture: got P=%b V=%b expected 0000/0", PENDING, VALID);
        end
        REQ_L = 4'b1111;
        idle(4);
        EI_L  = 1'b0;
        REQ_L = 4'b1101;
        idle(3);
        vectors++;
        if (PENDING !== 4'b0010) begin
            miscompares++;
            $display("FAIL en_preload: got %b expected 0010", PENDING);
        end
        EI_L = 1'b1;
        idle(4);
        vectors++;
        if (VALID !== 1'b0 || PENDING !== 4'b0010) begin
            miscompares++;
            $display("FAIL en_block_grant: got V=%b P=%b expected 0/0010", VALID, PENDING);
        end
        EI_L = 1'b0;
        exp_q.push_back(2'd1);
        tick();
        vectors++;
        if (VALID !== 1'b1 || {B, A} !== 2'b01) begin
            miscompares++;
            $display("FAIL en_release_grant: got V=%b BA=%b expected 1/01", VALID, {B, A});
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        vectors++;
        if (PENDING !== 4'b0000) begin
            miscompares++;
            $display("FAIL en_final: got %b expected 0000", PENDING);
        end
        REQ_L = 4'b1111;
        idle(4);
    endtask

    task automatic test_overrun_collision();
        bit ok;
        REQ_L = 4'b1011;
        exp_q.push_back(2'd2);
        wait_valid(8, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ovr_grant: VALID got 0 expected 1 within 8 cycles");
        end
        REQ_L = 4'b1111;
        idle(3);
        // Second fall on the still-pending line 2
        REQ_L = 4'b1011;
        idle(2);
        vectors++;
        if (OVERRUN !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_early: got %b expected 0", OVERRUN);
        end
        tick();
        vectors++;
        if (OVERRUN !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_pulse: got %b expected 1", OVERRUN);
        end
        tick();
        vectors++;
        if (OVERRUN !== 1'b0 || PENDING !== 4'b0100 || VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_after: got O=%b P=%b V=%b expected 0/0100/1", OVERRUN, PENDING, VALID);
        end
        REQ_L = 4'b1111;
        idle(3);
        // Third fall timed so the capture lands on the CLEAR cycle
        REQ_L = 4'b1011;
        tick();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        vectors++;
        if (VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_ack: got V=%b expected 0", VALID);
        end
        exp_q.push_back(2'd2);
        tick();
        vectors++;
        if (PENDING !== 4'b0100 || OVERRUN !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_set_wins: got P=%b O=%b expected 0100/0", PENDING, OVERRUN);
        end
        tick();
        vectors++;
        if (VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_regrant: got V=%b O=%b expected 1/0", VALID, OVERRUN);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        REQ_L = 4'b1111;
        idle(4);
        vectors++;
        if (PENDING !== 4'b0000 || VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_final: got P=%b V=%b expected 0000/0", PENDING, VALID);
        end
    endtask

    task automatic test_back_to_back();
        int valid_cycles;
        ACK   = 1'b1;
        REQ_L = 4'b0000;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        valid_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (VALID === 1'b1) valid_cycles++;
            if (i == 6) begin
                vectors++;
                if (VALID !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: VALID at cycle 7 got %b expected 1", VALID);
                end
            end
        end
        vectors++;
        if (valid_cycles != 4) begin
            miscompares++;
            $display("FAIL b2b_grant_count: got %0d expected 4", valid_cycles);
        end
        idle(4);
        vectors++;
        if (PENDING !== 4'b0000 || VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_held_low_once: got P=%b V=%b expected 0000/0", PENDING, VALID);
        end
        ACK   = 1'b0;
        REQ_L = 4'b1111;
        idle(4);
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        REQ_L = 4'b1110;
        exp_q.push_back(2'd0);
        wait_valid(8, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rmg_grant: VALID got 0 expected 1 within 8 cycles");
        end
        RESET = 1'b1;
        REQ_L = 4'b1111;
        tick();
        RESET = 1'b0;
        vectors++;
        if ({PENDING, VALID, B, A} !== 7'b0) begin
            miscompares++;
            $display("FAIL rmg_abandon: got P=%b V=%b BA=%b expected all 0", PENDING, VALID, {B, A});
        end
        idle(5);
        vectors++;
        if (VALID !== 1'b0 || PENDING !== 4'b0000) begin
            miscompares++;
            $display("FAIL rmg_quiet: got V=%b P=%b expected 0/0000", VALID, PENDING);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_stability();
        test_enable();
        test_overrun_collision();
        test_back_to_back();
        test_reset_mid_grant();
        idle(2);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d outstanding grants expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
